// File: rtl/fft_power_averager.sv
// rtl/fft_power_averager.sv - per-bin power averaging over 2^AVG_LOG2 FFT frames
//
// Computes re^2+im^2 for each incoming FFT bin, accumulates it per bin in a RAM
// over 2^AVG_LOG2 frames, then streams the floor mean in ascending bin order.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   in_real, in_imag  signed FFT bin components (DATA_WIDTH)
//   in_valid          one bin per asserted cycle, no backpressure
//   in_index          bin index, a permutation of 0..FFT_SIZE-1 per frame
//   restart           sync pulse: abort period/dump, resume at next frame start
//   out_power         averaged power, unsigned (PWR_WIDTH)
//   out_bin           bin number of out_power
//   out_valid/ready   output handshake
//   out_last          marks bin FFT_SIZE-1 of a dump
//   overrun_flag      sticky: a whole frame was dropped
//   busy              high while draining or dumping
module fft_power_averager #(
    parameter int FFT_SIZE   = 4096,
    parameter int DATA_WIDTH = 24,
    parameter int AVG_LOG2   = 3,
    parameter int PWR_WIDTH  = 2*DATA_WIDTH
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [DATA_WIDTH-1:0]       in_real,
    input  logic [DATA_WIDTH-1:0]       in_imag,
    input  logic                        in_valid,
    input  logic [$clog2(FFT_SIZE)-1:0] in_index,
    input  logic                        restart,
    output logic [PWR_WIDTH-1:0]        out_power,
    output logic [$clog2(FFT_SIZE)-1:0] out_bin,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        out_last,
    output logic                        overrun_flag,
    output logic                        busy
);
    localparam int IDX_W = $clog2(FFT_SIZE);
    localparam int ACC_W = PWR_WIDTH + AVG_LOG2;
    localparam int FC_W  = AVG_LOG2 + 1;
    localparam logic [FC_W-1:0]  FRAMES   = FC_W'(2**AVG_LOG2);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FFT_SIZE-1);

    typedef enum logic [1:0] {ACCUM, DRAIN, DUMP} state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        sample_cnt_q, sample_cnt_d;
    logic [FC_W-1:0]         frame_cnt_q, frame_cnt_d;
    logic                    frame_acc_q, frame_acc_d;
    logic                    overrun_q, overrun_d;
    // Three-stage write pipeline: capture, square/read, add; write on the next edge.
    logic                    v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
    logic [IDX_W-1:0]        idx1_q, idx1_d, idx2_q, idx2_d, idx3_q, idx3_d;
    logic                    ovw1_q, ovw1_d, ovw2_q, ovw2_d;
    logic [DATA_WIDTH-1:0]   re1_q, re1_d, im1_q, im1_d;
    logic [PWR_WIDTH-1:0]    pwr2_q, pwr2_d;
    logic [ACC_W-1:0]        wdata3_q, wdata3_d;
    logic                    fwd_hit_q, fwd_hit_d;
    logic [ACC_W-1:0]        fwd_data_q, fwd_data_d;
    logic [IDX_W-1:0]        rd_addr_q, rd_addr_d;
    logic                    out_valid_q, out_valid_d, out_last_q, out_last_d;
    logic [PWR_WIDTH-1:0]    out_power_q, out_power_d;
    logic [IDX_W-1:0]        out_bin_q, out_bin_d;

    logic [ACC_W-1:0]        mem [FFT_SIZE];
    logic [ACC_W-1:0]        rd_data_q;
    logic [IDX_W-1:0]        ram_raddr;

    logic                    first_s, last_s, take, load;
    logic [FC_W-1:0]         fc_next;
    logic [2*DATA_WIDTH-1:0] re_x, im_x, sq_re, sq_im;
    logic [ACC_W-1:0]        old_acc;

    always_comb begin
        state_d      = state_q;
        sample_cnt_d = sample_cnt_q;
        frame_cnt_d  = frame_cnt_q;
        frame_acc_d  = frame_acc_q;
        overrun_d    = overrun_q;
        rd_addr_d    = rd_addr_q;
        out_valid_d  = out_valid_q;
        out_last_d   = out_last_q;
        out_power_d  = out_power_q;
        out_bin_d    = out_bin_q;
        load         = 1'b0;
        fc_next      = frame_cnt_q + FC_W'(1);

        first_s = in_valid && (sample_cnt_q == '0);
        last_s  = in_valid && (sample_cnt_q == LAST_IDX);
        // A frame's fate is decided at its first sample and held for the tail.
        take    = in_valid && !restart && (first_s ? (state_q == ACCUM) : frame_acc_q);

        if (in_valid) sample_cnt_d = sample_cnt_q + IDX_W'(1);
        if (first_s) begin
            frame_acc_d = (state_q == ACCUM);
            if (state_q != ACCUM) overrun_d = 1'b1;
        end

        v1_d   = take;
        idx1_d = in_index;
        re1_d  = in_real;
        im1_d  = in_imag;
        ovw1_d = (frame_cnt_q == '0);

        // Sign-extend then square; the low 2*DW bits are the exact non-negative square.
        re_x   = {{DATA_WIDTH{re1_q[DATA_WIDTH-1]}}, re1_q};
        im_x   = {{DATA_WIDTH{im1_q[DATA_WIDTH-1]}}, im1_q};
        sq_re  = re_x * re_x;
        sq_im  = im_x * im_x;
        v2_d   = v1_q;
        idx2_d = idx1_q;
        ovw2_d = ovw1_q;
        pwr2_d = PWR_WIDTH'(sq_re) + PWR_WIDTH'(sq_im);

        // Newest pending value wins: the word about to be written (stage 3), then the
        // word that was written on the same edge as this item's RAM read.
        if (v3_q && (idx3_q == idx2_q))
            old_acc = wdata3_q;
        else if (fwd_hit_q)
            old_acc = fwd_data_q;
        else
            old_acc = rd_data_q;
        v3_d       = v2_q;
        idx3_d     = idx2_q;
        wdata3_d   = ovw2_q ? ACC_W'(pwr2_q) : old_acc + ACC_W'(pwr2_q);
        fwd_hit_d  = v3_q && (idx3_q == idx1_q);
        fwd_data_d = wdata3_q;

        case (state_q)
            ACCUM: begin
                if (take && last_s) begin
                    if (fc_next == FRAMES) begin
                        frame_cnt_d = '0;
                        state_d     = DRAIN;
                    end else begin
                        frame_cnt_d = fc_next;
                    end
                end
            end
            DRAIN: begin
                if (!v1_q && !v2_q && !v3_q) begin
                    state_d   = DUMP;
                    rd_addr_d = '0;
                end
            end
            DUMP: begin
                load = !(out_valid_q && out_last_q) && (!out_valid_q || out_ready);
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    if (out_last_q) begin
                        out_last_d = 1'b0;
                        state_d    = ACCUM;
                    end
                end
                if (load) begin
                    out_valid_d = 1'b1;
                    out_power_d = rd_data_q[ACC_W-1:AVG_LOG2];
                    out_bin_d   = rd_addr_q;
                    out_last_d  = (rd_addr_q == LAST_IDX);
                    rd_addr_d   = rd_addr_q + IDX_W'(1);
                end
            end
            default: state_d = ACCUM;
        endcase

        if (restart) begin
            state_d     = ACCUM;
            frame_cnt_d = '0;
            frame_acc_d = 1'b0;
            overrun_d   = 1'b0;
            v1_d        = 1'b0;
            v2_d        = 1'b0;
            v3_d        = 1'b0;
            fwd_hit_d   = 1'b0;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end

        // The dump reads with the next-cycle address so rd_data_q always matches
        // rd_addr_q, giving one word per cycle without a skid buffer.
        ram_raddr = (state_d == DUMP) ? rd_addr_d : idx1_q;
    end

    always_ff @(posedge clk) begin
        if (v3_q) mem[idx3_q] <= wdata3_q;
        rd_data_q <= mem[ram_raddr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ACCUM;
            sample_cnt_q <= '0;
            frame_cnt_q  <= '0;
            frame_acc_q  <= 1'b0;
            overrun_q    <= 1'b0;
            v1_q         <= 1'b0;
            v2_q         <= 1'b0;
            v3_q         <= 1'b0;
            idx1_q       <= '0;
            idx2_q       <= '0;
            idx3_q       <= '0;
            ovw1_q       <= 1'b0;
            ovw2_q       <= 1'b0;
            re1_q        <= '0;
            im1_q        <= '0;
            pwr2_q       <= '0;
            wdata3_q     <= '0;
            fwd_hit_q    <= 1'b0;
            fwd_data_q   <= '0;
            rd_addr_q    <= '0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            out_power_q  <= '0;
            out_bin_q    <= '0;
        end else begin
            state_q      <= state_d;
            sample_cnt_q <= sample_cnt_d;
            frame_cnt_q  <= frame_cnt_d;
            frame_acc_q  <= frame_acc_d;
            overrun_q    <= overrun_d;
            v1_q         <= v1_d;
            v2_q         <= v2_d;
            v3_q         <= v3_d;
            idx1_q       <= idx1_d;
            idx2_q       <= idx2_d;
            idx3_q       <= idx3_d;
            ovw1_q       <= ovw1_d;
            ovw2_q       <= ovw2_d;
            re1_q        <= re1_d;
            im1_q        <= im1_d;
            pwr2_q       <= pwr2_d;
            wdata3_q     <= wdata3_d;
            fwd_hit_q    <= fwd_hit_d;
            fwd_data_q   <= fwd_data_d;
            rd_addr_q    <= rd_addr_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            out_power_q  <= out_power_d;
            out_bin_q    <= out_bin_d;
        end
    end

    assign out_power    = out_power_q;
    assign out_bin      = out_bin_q;
    assign out_valid    = out_valid_q;
    assign out_last     = out_last_q;
    assign overrun_flag = overrun_q;
    assign busy         = (state_q != ACCUM);
endmodule

// File: tb/tb_fft_power_averager.sv
// tb/tb_fft_power_averager.sv - scoreboard bench for fft_power_averager (AVG_LOG2 = 3, 0, 1)
module tb_fft_power_averager;
    localparam int N  = 64;
    localparam int DW = 24;
    localparam int PW = 48;
    localparam int IW = 6;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] in_real = '0;
    logic [DW-1:0] in_imag = '0;
    logic          in_valid = 1'b0;
    logic [IW-1:0] in_index = '0;
    logic          restart = 1'b0;
    logic          out_ready = 1'b1;

    logic [PW-1:0] o_pow  [3];
    logic [IW-1:0] o_bin  [3];
    logic          o_val  [3];
    logic          o_last [3];
    logic          o_ovr  [3];
    logic          o_busy [3];

    typedef struct {
        logic [PW-1:0] pwr;
        logic [IW-1:0] bin;
        logic          last;
    } exp_t;

    exp_t          sb[$];
    exp_t          mon_e;
    int            checks = 0;
    int            errors = 0;
    int            mon_sel = -1;
    int            mk;
    bit            ready_rand = 1'b0;
    bit            hold_pend = 1'b0;
    logic [PW-1:0] hold_pow;
    logic [IW-1:0] hold_bin;
    logic          hold_last;

    always #5 clk = ~clk;

    fft_power_averager #(.FFT_SIZE(N), .DATA_WIDTH(DW), .AVG_LOG2(3)) u_avg3 (
        .clk(clk), .rst_n(rst_n), .in_real(in_real), .in_imag(in_imag), .in_valid(in_valid),
        .in_index(in_index), .restart(restart), .out_power(o_pow[0]), .out_bin(o_bin[0]),
        .out_valid(o_val[0]), .out_ready(out_ready), .out_last(o_last[0]),
        .overrun_flag(o_ovr[0]), .busy(o_busy[0]));
    fft_power_averager #(.FFT_SIZE(N), .DATA_WIDTH(DW), .AVG_LOG2(0)) u_avg0 (
        .clk(clk), .rst_n(rst_n), .in_real(in_real), .in_imag(in_imag), .in_valid(in_valid),
        .in_index(in_index), .restart(restart), .out_power(o_pow[1]), .out_bin(o_bin[1]),
        .out_valid(o_val[1]), .out_ready(out_ready), .out_last(o_last[1]),
        .overrun_flag(o_ovr[1]), .busy(o_busy[1]));
    fft_power_averager #(.FFT_SIZE(N), .DATA_WIDTH(DW), .AVG_LOG2(1)) u_avg1 (
        .clk(clk), .rst_n(rst_n), .in_real(in_real), .in_imag(in_imag), .in_valid(in_valid),
        .in_index(in_index), .restart(restart), .out_power(o_pow[2]), .out_bin(o_bin[2]),
        .out_valid(o_val[2]), .out_ready(out_ready), .out_last(o_last[2]),
        .overrun_flag(o_ovr[2]), .busy(o_busy[2]));

    initial begin
        forever begin
            @(posedge clk);
            #1;
            out_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    always @(negedge clk) begin
        if (mon_sel >= 0 && rst_n) begin
            mk = mon_sel;
            if (hold_pend) begin
                checks++;
                if (o_val[mk] !== 1'b1 || o_pow[mk] !== hold_pow || o_bin[mk] !== hold_bin || o_last[mk] !== hold_last) begin
                    errors++;
                    $display("FAIL stall_hold dut%0d: got v=%0b pwr=%0d bin=%0d last=%0b, required v=1 pwr=%0d bin=%0d last=%0b",
                             mk, o_val[mk], o_pow[mk], o_bin[mk], o_last[mk], hold_pow, hold_bin, hold_last);
                end
            end
            if (o_val[mk] === 1'b1) begin
                checks++;
                if (o_busy[mk] !== 1'b1) begin
                    errors++;
                    $display("FAIL valid_outside_dump dut%0d: busy=%0b required 1", mk, o_busy[mk]);
                end
            end
            if (o_val[mk] === 1'b1 && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output dut%0d: bin=%0d pwr=%0d, required no output", mk, o_bin[mk], o_pow[mk]);
                end else begin
                    mon_e = sb.pop_front();
                    if (o_pow[mk] !== mon_e.pwr || o_bin[mk] !== mon_e.bin || o_last[mk] !== mon_e.last) begin
                        errors++;
                        $display("FAIL dump_word dut%0d: got pwr=%0d bin=%0d last=%0b, required pwr=%0d bin=%0d last=%0b",
                                 mk, o_pow[mk], o_bin[mk], o_last[mk], mon_e.pwr, mon_e.bin, mon_e.last);
                    end
                end
            end
            hold_pend = (o_val[mk] === 1'b1) && !out_ready;
            hold_pow  = o_pow[mk];
            hold_bin  = o_bin[mk];
            hold_last = o_last[mk];
        end else begin
            hold_pend = 1'b0;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input int re_base, input int re_step, input int im_val);
        for (int i = 0; i < N; i++) begin
            int k = (i * 37) % N;
            in_valid = 1'b1;
            in_index = IW'(k);
            in_real  = DW'(re_base + re_step * k);
            in_imag  = DW'(im_val);
            tick(1);
        end
        in_valid = 1'b0;
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        tick(1);
        restart = 1'b0;
    endtask

    task automatic push_const(input logic [PW-1:0] p);
        for (int b = 0; b < N; b++) begin
            exp_t e;
            e.pwr  = p;
            e.bin  = IW'(b);
            e.last = (b == N-1);
            sb.push_back(e);
        end
    endtask

    task automatic wait_dump(input string name);
        int c = 0;
        int k = mon_sel;
        while (sb.size() != 0 && c < 2000) begin
            tick(1);
            c++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s dump_timeout: remaining=%0d required 0", name, sb.size());
            sb.delete();
        end
        checks++;
        if (o_val[k] !== 1'b0 || o_busy[k] !== 1'b0) begin
            errors++;
            $display("FAIL %s end_of_dump: valid=%0b busy=%0b required 0 0", name, o_val[k], o_busy[k]);
        end
        mon_sel = -1;
        tick(2);
    endtask

    task automatic wait_valid(input int k, input string name, output int c);
        c = 0;
        while (o_val[k] !== 1'b1 && c < 20) begin
            tick(1);
            c++;
        end
        checks++;
        if (o_val[k] !== 1'b1) begin
            errors++;
            $display("FAIL %s no_valid: out_valid=%0b required 1 within 20 cycles", name, o_val[k]);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(3);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (o_val[k] !== 1'b0 || o_last[k] !== 1'b0 || o_ovr[k] !== 1'b0 || o_busy[k] !== 1'b0) begin
                errors++;
                $display("FAIL reset_flags dut%0d: v=%0b last=%0b ovr=%0b busy=%0b required all 0",
                         k, o_val[k], o_last[k], o_ovr[k], o_busy[k]);
            end
            checks++;
            if (o_pow[k] !== '0 || o_bin[k] !== '0) begin
                errors++;
                $display("FAIL reset_data dut%0d: pwr=%0d bin=%0d required 0 0", k, o_pow[k], o_bin[k]);
            end
        end
        rst_n = 1'b1;
        tick(2);
    endtask

    task automatic test_constant_avg();
        int c;
        mon_sel = 0;
        push_const(48'd1000000);
        repeat (8) send_frame(1000, 0, 0);
        wait_valid(0, "const_avg", c);
        checks++;
        if (c > 6) begin
            errors++;
            $display("FAIL const_avg latency: got %0d cycles, required <= 6", c);
        end
        wait_dump("const_avg");
    endtask

    task automatic test_full_scale();
        pulse_restart();
        mon_sel = 1;
        push_const(48'h8000_0000_0000);
        send_frame(-8388608, 0, -8388608);
        wait_dump("full_scale");
    endtask

    task automatic test_floor();
        pulse_restart();
        mon_sel = 2;
        push_const(48'd2);
        send_frame(1, 0, 0);
        send_frame(2, 0, 0);
        wait_dump("floor");
    endtask

    task automatic test_backpressure();
        pulse_restart();
        mon_sel = 0;
        for (int k = 0; k < N; k++) begin
            exp_t   e;
            longint sum = 0;
            for (int f = 0; f < 8; f++) begin
                longint re = 3 * f - 100 + 5 * k;
                longint im = f - 4;
                sum += re * re + im * im;
            end
            e.pwr  = PW'(sum >> 3);
            e.bin  = IW'(k);
            e.last = (k == N-1);
            sb.push_back(e);
        end
        ready_rand = 1'b1;
        for (int f = 0; f < 8; f++) send_frame(3 * f - 100, 5, f - 4);
        wait_dump("backpressure");
        ready_rand = 1'b0;
        tick(1);
    endtask

    task automatic test_overrun();
        pulse_restart();
        mon_sel = 0;
        push_const(48'd25);
        repeat (8) send_frame(5, 0, 0);
        send_frame(777, 0, 0);
        checks++;
        if (o_ovr[0] !== 1'b1) begin
            errors++;
            $display("FAIL overrun_set: overrun_flag=%0b required 1", o_ovr[0]);
        end
        wait_dump("overrun_dump");
        mon_sel = 0;
        push_const(48'd100);
        repeat (8) send_frame(10, 0, 0);
        wait_dump("after_overrun");
        checks++;
        if (o_ovr[0] !== 1'b1) begin
            errors++;
            $display("FAIL overrun_sticky: overrun_flag=%0b required 1", o_ovr[0]);
        end
        pulse_restart();
        checks++;
        if (o_ovr[0] !== 1'b0) begin
            errors++;
            $display("FAIL overrun_clear: overrun_flag=%0b required 0", o_ovr[0]);
        end
    endtask

    task automatic test_restart_reset();
        int c;
        pulse_restart();
        repeat (8) send_frame(7, 0, 0);
        wait_valid(0, "reset_mid_dump", c);
        tick(10);
        rst_n = 1'b0;
        #1;
        checks++;
        if (o_val[0] !== 1'b0 || o_busy[0] !== 1'b0 || o_last[0] !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_dump: v=%0b busy=%0b last=%0b required 0 0 0", o_val[0], o_busy[0], o_last[0]);
        end
        tick(1);
        rst_n = 1'b1;
        tick(1);
        mon_sel = 0;
        push_const(48'd9);
        repeat (8) send_frame(3, 0, 0);
        wait_dump("after_reset");

        repeat (8) send_frame(11, 0, 0);
        wait_valid(0, "restart_mid_dump", c);
        tick(5);
        pulse_restart();
        checks++;
        if (o_val[0] !== 1'b0 || o_busy[0] !== 1'b0) begin
            errors++;
            $display("FAIL restart_mid_dump: v=%0b busy=%0b required 0 0", o_val[0], o_busy[0]);
        end
        tick(3);
        repeat (3) send_frame(50, 0, 0);
        pulse_restart();
        mon_sel = 0;
        push_const(48'd9);
        repeat (8) send_frame(3, 0, 0);
        wait_dump("after_restart");
    endtask

    initial begin
        test_reset();
        test_constant_avg();
        test_full_scale();
        test_floor();
        test_backpressure();
        test_overrun();
        test_restart_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
